// File: rtl/alu_pkg.sv
// Shared ALU opcode constants, default width and sequencer state type.
package alu_pkg;

  localparam int XLEN_DEFAULT = 32;

  localparam logic [4:0] ALU_ADD    = 5'h00;
  localparam logic [4:0] ALU_SUB    = 5'h01;
  localparam logic [4:0] ALU_SLL    = 5'h02;
  localparam logic [4:0] ALU_SLT    = 5'h03;
  localparam logic [4:0] ALU_SLTU   = 5'h04;
  localparam logic [4:0] ALU_XOR    = 5'h05;
  localparam logic [4:0] ALU_SRL    = 5'h06;
  localparam logic [4:0] ALU_SRA    = 5'h07;
  localparam logic [4:0] ALU_OR     = 5'h08;
  localparam logic [4:0] ALU_AND    = 5'h09;
  localparam logic [4:0] ALU_MUL    = 5'h10;
  localparam logic [4:0] ALU_MULH   = 5'h11;
  localparam logic [4:0] ALU_MULHSU = 5'h12;
  localparam logic [4:0] ALU_MULHU  = 5'h13;
  localparam logic [4:0] ALU_DIV    = 5'h14;
  localparam logic [4:0] ALU_DIVU   = 5'h15;
  localparam logic [4:0] ALU_REM    = 5'h16;
  localparam logic [4:0] ALU_REMU   = 5'h17;
  localparam logic [4:0] ALU_X      = 5'h1F;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } alu_state_e;

endpackage

// File: rtl/alu_muldiv_iter.sv
// Bit-serial radix-2 multiplier / restoring divider on one shared adder (built when ALU_SEQ_MDU_EN
// is defined). Works on operand magnitudes; signs and divide corner cases are fixed up at the end.
module alu_muldiv_iter
  import alu_pkg::*;
#(
  parameter int XLEN = XLEN_DEFAULT
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start_i,
  input  logic            kill_i,
  input  logic [4:0]      fn_i,
  input  logic [XLEN-1:0] a_i,
  input  logic [XLEN-1:0] b_i,
  output logic            done_o,
  output logic [XLEN-1:0] result_o
);

  localparam int CNT_W = $clog2(XLEN);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(XLEN - 1);

  logic             active_q, active_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [4:0]       fn_q, fn_d;
  logic [XLEN-1:0]  acc_q, acc_d, lo_q, lo_d, opb_q, opb_d;
  logic             neg_res_q, neg_res_d, neg_rem_q, neg_rem_d;

  logic            a_sgn, b_sgn, mode_div, ge;
  logic [XLEN-1:0] a_mag, b_mag, step_acc, step_lo, hi_n;
  logic [XLEN:0]   rem_sh;
  logic [XLEN+1:0] add_x, add_y, add_s;

  assign a_sgn = (fn_i inside {ALU_MULH, ALU_MULHSU, ALU_DIV, ALU_REM}) && a_i[XLEN-1];
  assign b_sgn = (fn_i inside {ALU_MULH, ALU_DIV, ALU_REM}) && b_i[XLEN-1];
  assign a_mag = a_sgn ? -a_i : a_i;
  assign b_mag = b_sgn ? -b_i : b_i;
  assign mode_div = fn_q inside {ALU_DIV, ALU_DIVU, ALU_REM, ALU_REMU};
  assign done_o = active_q && (cnt_q == CNT_LAST);

  // One step: multiply adds the multiplicand and shifts right; divide trial-subtracts and shifts left
  always_comb begin
    rem_sh = {acc_q, lo_q[XLEN-1]};
    add_x  = mode_div ? {1'b0, rem_sh} : {2'b00, acc_q};
    add_y  = mode_div ? ~{2'b00, opb_q} : (lo_q[0] ? {2'b00, opb_q} : '0);
    add_s  = add_x + add_y + {{(XLEN+1){1'b0}}, mode_div};
    ge     = ~add_s[XLEN+1];
    if (mode_div) begin
      step_acc = ge ? add_s[XLEN-1:0] : rem_sh[XLEN-1:0];
      step_lo  = {lo_q[XLEN-2:0], ge};
    end else begin
      step_acc = add_s[XLEN:1];
      step_lo  = {add_s[0], lo_q[XLEN-1:1]};
    end
  end

  // Divide by zero yields an all-ones magnitude quotient, so its negation is suppressed; the
  // most-negative / -1 overflow falls out of the magnitude arithmetic as in_a and 0.
  always_comb begin
    hi_n = neg_res_q ? (~step_acc + {{(XLEN-1){1'b0}}, (step_lo == '0)}) : step_acc;
    case (fn_q)
      ALU_MUL:                        result_o = step_lo;
      ALU_MULH, ALU_MULHSU, ALU_MULHU: result_o = hi_n;
      ALU_DIV, ALU_DIVU:              result_o = neg_res_q ? -step_lo : step_lo;
      ALU_REM, ALU_REMU:              result_o = neg_rem_q ? -step_acc : step_acc;
      default:                        result_o = '0;
    endcase
  end

  always_comb begin
    active_d  = active_q;
    cnt_d     = cnt_q;
    fn_d      = fn_q;
    acc_d     = acc_q;
    lo_d      = lo_q;
    opb_d     = opb_q;
    neg_res_d = neg_res_q;
    neg_rem_d = neg_rem_q;
    if (kill_i) begin
      active_d = 1'b0;
    end else if (start_i) begin
      active_d  = 1'b1;
      cnt_d     = '0;
      fn_d      = fn_i;
      acc_d     = '0;
      lo_d      = a_mag;
      opb_d     = b_mag;
      neg_res_d = (a_sgn ^ b_sgn) && (b_i != '0);
      neg_rem_d = a_sgn;
    end else if (active_q) begin
      cnt_d = cnt_q + 1'b1;
      acc_d = step_acc;
      lo_d  = step_lo;
      if (done_o) active_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      active_q <= 1'b0;
      cnt_q    <= '0;
      fn_q     <= ALU_X;
    end else begin
      active_q <= active_d;
      cnt_q    <= cnt_d;
      fn_q     <= fn_d;
    end
  end

  always_ff @(posedge clk) begin
    acc_q     <= acc_d;
    lo_q      <= lo_d;
    opb_q     <= opb_d;
    neg_res_q <= neg_res_d;
    neg_rem_q <= neg_rem_d;
  end

endmodule

// File: rtl/alu_seq.sv
// Handshaked integer execution unit: single-cycle ALU ops plus, when ALU_SEQ_MDU_EN is defined,
// the M-extension multiply/divide group on an iterative engine (XLEN+1 cycle latency).
module alu_seq
  import alu_pkg::*;
#(
  parameter int XLEN = XLEN_DEFAULT
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [4:0]      in_fn,
  input  logic [XLEN-1:0] in_a,
  input  logic [XLEN-1:0] in_b,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_result,
  output logic            out_illegal
);

  localparam int SHAMT_W = $clog2(XLEN);

  alu_state_e      state_q, state_d;
  logic [XLEN-1:0] out_result_q, out_result_d;
  logic            out_illegal_q, out_illegal_d;

  logic                   accept, is_mop, sc_illegal;
  logic [XLEN-1:0]        sc_result;
  logic [SHAMT_W-1:0]     shamt;
  logic signed [XLEN-1:0] a_s, b_s;

  assign in_ready    = rst_n && !flush && (state_q == IDLE || (state_q == DONE && out_ready));
  assign accept      = in_valid && in_ready;
  assign out_valid   = (state_q == DONE);
  assign out_result  = out_result_q;
  assign out_illegal = out_illegal_q;

  assign shamt = in_b[SHAMT_W-1:0];
  assign a_s   = in_a;
  assign b_s   = in_b;

  always_comb begin
    sc_result  = '0;
    sc_illegal = 1'b0;
    case (in_fn)
      ALU_ADD:  sc_result = in_a + in_b;
      ALU_SUB:  sc_result = in_a - in_b;
      ALU_AND:  sc_result = in_a & in_b;
      ALU_OR:   sc_result = in_a | in_b;
      ALU_XOR:  sc_result = in_a ^ in_b;
      ALU_SLL:  sc_result = in_a << shamt;
      ALU_SRL:  sc_result = in_a >> shamt;
      ALU_SRA:  sc_result = $unsigned(a_s >>> shamt);
      ALU_SLT:  sc_result = {{(XLEN-1){1'b0}}, (a_s < b_s)};
      ALU_SLTU: sc_result = {{(XLEN-1){1'b0}}, (in_a < in_b)};
      default:  sc_illegal = 1'b1;
    endcase
  end

`ifdef ALU_SEQ_MDU_EN
  logic            mdu_start, mdu_done;
  logic [XLEN-1:0] mdu_result;

  assign is_mop    = in_fn inside {ALU_MUL, ALU_MULH, ALU_MULHSU, ALU_MULHU,
                                   ALU_DIV, ALU_DIVU, ALU_REM, ALU_REMU};
  assign mdu_start = accept && is_mop;

  alu_muldiv_iter #(.XLEN(XLEN)) u_muldiv (
    .clk      (clk),
    .rst_n    (rst_n),
    .start_i  (mdu_start),
    .kill_i   (flush),
    .fn_i     (in_fn),
    .a_i      (in_a),
    .b_i      (in_b),
    .done_o   (mdu_done),
    .result_o (mdu_result)
  );
`else
  assign is_mop = 1'b0;
`endif

  // A new request accepted while a result drains overrides the DONE->IDLE move; flush beats all
  always_comb begin
    state_d       = state_q;
    out_result_d  = out_result_q;
    out_illegal_d = out_illegal_q;
    case (state_q)
      IDLE: ;
      BUSY: begin
`ifdef ALU_SEQ_MDU_EN
        if (mdu_done) begin
          state_d       = DONE;
          out_result_d  = mdu_result;
          out_illegal_d = 1'b0;
        end
`endif
      end
      DONE: if (out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (accept) begin
      if (is_mop) begin
        state_d = BUSY;
      end else begin
        state_d       = DONE;
        out_result_d  = sc_result;
        out_illegal_d = sc_illegal;
      end
    end
    if (flush) state_d = IDLE;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      out_result_q  <= '0;
      out_illegal_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      out_result_q  <= out_result_d;
      out_illegal_q <= out_illegal_d;
    end
  end

endmodule

// File: tb/tb_alu_seq.sv
// Self-checking bench for alu_seq: directed vector table, handshake/flush/reset sequences and
// randomized ops against an arithmetic reference model.
module tb_alu_seq;
  import alu_pkg::*;

  localparam int XLEN = 32;
`ifdef ALU_SEQ_MDU_EN
  localparam int MLAT = XLEN + 1;
`endif

  logic            clk, rst_n, flush, in_valid, in_ready, out_valid, out_ready, out_illegal;
  logic [4:0]      in_fn;
  logic [XLEN-1:0] in_a, in_b, out_result;

  int checks = 0;
  int errors = 0;

  alu_seq #(.XLEN(XLEN)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .flush       (flush),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_fn       (in_fn),
    .in_a        (in_a),
    .in_b        (in_b),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_result  (out_result),
    .out_illegal (out_illegal)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [4:0]  fn;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] r;
    logic        il;
    int          lat;
  } vec_t;

  vec_t tbl[$];

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h expected=%h", nm, got, exp);
    end
  endtask

  task automatic add_vec(input logic [4:0] fn, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] r, input logic il, input int lat);
    vec_t v;
    v.fn = fn; v.a = a; v.b = b; v.r = r; v.il = il; v.lat = lat;
    tbl.push_back(v);
  endtask

  // Reference: plain integer arithmetic from the operation definitions
  function automatic void model(input logic [4:0] fn, input logic [31:0] a, input logic [31:0] b,
                                output logic [31:0] r, output logic il, output int lat);
`ifdef ALU_SEQ_MDU_EN
    longint          sa, sb;
    longint unsigned ua, ub;
    logic [63:0]     p;
    int              ia, ib;
    sa = longint'($signed(a)); sb = longint'($signed(b));
    ua = {32'b0, a};           ub = {32'b0, b};
    ia = a;                    ib = b;
`endif
    r = '0; il = 1'b0; lat = 1;
    case (fn)
      ALU_ADD:  r = a + b;
      ALU_SUB:  r = a - b;
      ALU_AND:  r = a & b;
      ALU_OR:   r = a | b;
      ALU_XOR:  r = a ^ b;
      ALU_SLL:  r = a << b[4:0];
      ALU_SRL:  r = a >> b[4:0];
      ALU_SRA:  r = $unsigned($signed(a) >>> b[4:0]);
      ALU_SLT:  r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      ALU_SLTU: r = (a < b) ? 32'd1 : 32'd0;
`ifdef ALU_SEQ_MDU_EN
      ALU_MUL:    begin p = ua * ub; r = p[31:0]; lat = MLAT; end
      ALU_MULH:   begin p = sa * sb; r = p[63:32]; lat = MLAT; end
      ALU_MULHSU: begin p = sa * longint'(ua); r = p[63:32]; lat = MLAT; end
      ALU_MULHU:  begin p = ua * ub; r = p[63:32]; lat = MLAT; end
      ALU_DIV: begin
        lat = MLAT;
        if (b == 0) r = '1;
        else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) r = a;
        else r = ia / ib;
      end
      ALU_REM: begin
        lat = MLAT;
        if (b == 0) r = a;
        else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) r = '0;
        else r = ia % ib;
      end
      ALU_DIVU: begin lat = MLAT; r = (b == 0) ? '1 : a / b; end
      ALU_REMU: begin lat = MLAT; r = (b == 0) ? a : a % b; end
`endif
      default: il = 1'b1;
    endcase
  endfunction

  // Entered at a negedge; issues one request, waits for its result and consumes it
  task automatic run_op(input string nm, input logic [4:0] fn, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] er, input logic eil,
                        input int elat);
    int n;
    int lat;
    int busy_rdy;
    in_fn = fn; in_a = a; in_b = b; in_valid = 1'b1; out_ready = 1'b0;
    #1;
    n = 0;
    while (!in_ready && n < 100) begin
      @(negedge clk); #1; n++;
    end
    chk({nm, " in_ready"}, 32'(in_ready), 32'd1);
    @(negedge clk);
    in_valid = 1'b0;
    lat = 1;
    busy_rdy = 0;
    while (!out_valid && lat < 100) begin
      if (in_ready) busy_rdy++;
      @(negedge clk);
      lat++;
    end
    chk({nm, " latency"}, 32'(lat), 32'(elat));
    chk({nm, " result"}, out_result, er);
    chk({nm, " illegal"}, 32'(out_illegal), 32'(eil));
    if (elat > 1) chk({nm, " busy in_ready"}, 32'(busy_rdy), 32'd0);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  function automatic logic [31:0] rnd_op32();
    case ($urandom_range(0, 5))
      0: return 32'h0000_0000;
      1: return 32'h8000_0000;
      2: return 32'hFFFF_FFFF;
      3: return 32'h0000_0001;
      default: return $urandom;
    endcase
  endfunction

  initial begin
    logic [4:0]  fns[19];
    logic [31:0] ra, rb, er;
    logic        eil;
    int          elat;
    int          vcnt;
    logic [4:0]  rf;

    fns = '{ALU_ADD, ALU_SUB, ALU_SLL, ALU_SLT, ALU_SLTU, ALU_XOR, ALU_SRL, ALU_SRA, ALU_OR,
            ALU_AND, ALU_MUL, ALU_MULH, ALU_MULHSU, ALU_MULHU, ALU_DIV, ALU_DIVU, ALU_REM,
            ALU_REMU, ALU_X};

    add_vec(ALU_ADD,  32'h7FFF_FFFF, 32'h0000_0001, 32'h8000_0000, 1'b0, 1);
    add_vec(ALU_SRA,  32'h8000_0000, 32'h0000_0021, 32'hC000_0000, 1'b0, 1);
    add_vec(ALU_SUB,  32'h0000_0005, 32'h0000_0007, 32'hFFFF_FFFE, 1'b0, 1);
    add_vec(ALU_SLT,  32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0001, 1'b0, 1);
    add_vec(ALU_SLTU, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, 1'b0, 1);
    add_vec(ALU_SLT,  32'h8000_0000, 32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1);
    add_vec(ALU_SLTU, 32'h8000_0000, 32'h7FFF_FFFF, 32'h0000_0000, 1'b0, 1);
    add_vec(ALU_SLL,  32'h0000_0001, 32'h0000_003F, 32'h8000_0000, 1'b0, 1);
    add_vec(ALU_SRL,  32'h8000_0000, 32'h0000_0024, 32'h0800_0000, 1'b0, 1);
    add_vec(ALU_AND,  32'hF0F0_F0F0, 32'h0FF0_0FF0, 32'h00F0_00F0, 1'b0, 1);
    add_vec(ALU_OR,   32'hF0F0_F0F0, 32'h0F0F_0F0F, 32'hFFFF_FFFF, 1'b0, 1);
    add_vec(ALU_XOR,  32'hFFFF_0000, 32'h0F0F_0F0F, 32'hF0F0_0F0F, 1'b0, 1);
    add_vec(ALU_X,    32'h1234_5678, 32'h9ABC_DEF0, 32'h0000_0000, 1'b1, 1);
    add_vec(5'h0C,    32'h0000_0001, 32'h0000_0001, 32'h0000_0000, 1'b1, 1);
`ifdef ALU_SEQ_MDU_EN
    add_vec(ALU_MUL,    32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001, 1'b0, MLAT);
    add_vec(ALU_MULHU,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 1'b0, MLAT);
    add_vec(ALU_MULH,   32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 1'b0, MLAT);
    add_vec(ALU_MULHSU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, MLAT);
    add_vec(ALU_DIV,    32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1'b0, MLAT);
    add_vec(ALU_REM,    32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 1'b0, MLAT);
    add_vec(ALU_DIVU,   32'h0000_0007, 32'h0000_0000, 32'hFFFF_FFFF, 1'b0, MLAT);
    add_vec(ALU_REMU,   32'h0000_0007, 32'h0000_0000, 32'h0000_0007, 1'b0, MLAT);
    add_vec(ALU_DIV,    32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFD, 1'b0, MLAT);
    add_vec(ALU_REM,    32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 1'b0, MLAT);
    add_vec(ALU_DIV,    32'hFFFF_FFF9, 32'h0000_0000, 32'hFFFF_FFFF, 1'b0, MLAT);
    add_vec(ALU_REM,    32'hFFFF_FFF9, 32'h0000_0000, 32'hFFFF_FFF9, 1'b0, MLAT);
`else
    add_vec(ALU_MUL,    32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 1'b1, 1);
    add_vec(ALU_DIV,    32'h0000_0007, 32'h0000_0002, 32'h0000_0000, 1'b1, 1);
`endif

    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b1; out_ready = 1'b0;
    in_fn = ALU_ADD; in_a = 32'd1; in_b = 32'd2;
    #2;
    chk("reset out_valid", 32'(out_valid), 32'd0);
    chk("reset out_result", out_result, 32'd0);
    chk("reset out_illegal", 32'(out_illegal), 32'd0);
    chk("reset in_ready", 32'(in_ready), 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1; in_valid = 1'b0;
    @(negedge clk);
    chk("post-reset out_valid", 32'(out_valid), 32'd0);

    for (int i = 0; i < tbl.size(); i++)
      run_op($sformatf("vec%0d", i), tbl[i].fn, tbl[i].a, tbl[i].b, tbl[i].r, tbl[i].il,
             tbl[i].lat);

    // Back-to-back single-cycle ops at one per cycle
    out_ready = 1'b1; in_valid = 1'b1;
    in_fn = ALU_SUB; in_a = 32'd5; in_b = 32'd7;
    #1 chk("b2b ready0", 32'(in_ready), 32'd1);
    @(negedge clk);
    chk("b2b valid0", 32'(out_valid), 32'd1);
    chk("b2b sub", out_result, 32'hFFFF_FFFE);
    in_fn = ALU_SLT; in_a = 32'hFFFF_FFFF; in_b = 32'd1;
    #1 chk("b2b ready1", 32'(in_ready), 32'd1);
    @(negedge clk);
    chk("b2b valid1", 32'(out_valid), 32'd1);
    chk("b2b slt", out_result, 32'd1);
    in_fn = ALU_SLTU;
    #1 chk("b2b ready2", 32'(in_ready), 32'd1);
    @(negedge clk);
    chk("b2b valid2", 32'(out_valid), 32'd1);
    chk("b2b sltu", out_result, 32'd0);
    in_valid = 1'b0;
    @(negedge clk);
    chk("b2b drained", 32'(out_valid), 32'd0);
    out_ready = 1'b0;

    // Backpressure: result held, pending request ignored until released
    in_valid = 1'b1; in_fn = ALU_ADD; in_a = 32'd1; in_b = 32'd2;
    @(negedge clk);
    in_fn = ALU_XOR; in_a = 32'h0000_FF00; in_b = 32'h0000_0F0F;
    for (int k = 0; k < 5; k++) begin
      #1;
      chk($sformatf("hold%0d in_ready", k), 32'(in_ready), 32'd0);
      chk($sformatf("hold%0d valid", k), 32'(out_valid), 32'd1);
      chk($sformatf("hold%0d result", k), out_result, 32'd3);
      @(negedge clk);
    end
    out_ready = 1'b1;
    #1 chk("release in_ready", 32'(in_ready), 32'd1);
    @(negedge clk);
    in_valid = 1'b0;
    chk("release valid", 32'(out_valid), 32'd1);
    chk("release result", out_result, 32'h0000_F00F);
    @(negedge clk);
    chk("release drained", 32'(out_valid), 32'd0);
    out_ready = 1'b0;

    // Flush of a held result, with a request presented in the flush cycle
    in_valid = 1'b1; in_fn = ALU_AND; in_a = 32'h0000_FFFF; in_b = 32'h0000_0FF0;
    @(negedge clk);
    chk("flush pre valid", 32'(out_valid), 32'd1);
    flush = 1'b1;
    #1 chk("flush in_ready", 32'(in_ready), 32'd0);
    @(negedge clk);
    flush = 1'b0; in_valid = 1'b0;
    chk("flush kills result", 32'(out_valid), 32'd0);
    @(negedge clk);
    chk("flush no stale", 32'(out_valid), 32'd0);
    flush = 1'b1; in_valid = 1'b1; in_fn = ALU_ADD;
    @(negedge clk);
    flush = 1'b0; in_valid = 1'b0;
    @(negedge clk);
    chk("flush blocks accept", 32'(out_valid), 32'd0);
    run_op("after flush X", ALU_X, 32'h5, 32'h6, 32'h0, 1'b1, 1);

`ifdef ALU_SEQ_MDU_EN
    in_valid = 1'b1; in_fn = ALU_MUL; in_a = 32'hFFFF_FFFF; in_b = 32'hFFFF_FFFF;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (9) @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    vcnt = 0;
    repeat (40) begin
      if (out_valid) vcnt++;
      @(negedge clk);
    end
    chk("busy flush no result", 32'(vcnt), 32'd0);
    run_op("busy flush then X", ALU_X, 32'h0, 32'h0, 32'h0, 1'b1, 1);
`endif

    // Asynchronous reset with a result pending
    for (int k = 0; k < 2; k++) begin
      out_ready = 1'b0; in_valid = 1'b1;
      in_fn = (k == 0) ? ALU_ADD : ALU_X; in_a = 32'd5; in_b = 32'd6;
      @(negedge clk);
      in_valid = 1'b0;
      chk($sformatf("arst%0d pre valid", k), 32'(out_valid), 32'd1);
      chk($sformatf("arst%0d pre illegal", k), 32'(out_illegal), 32'(k));
      #2 rst_n = 1'b0;
      #1;
      chk($sformatf("arst%0d valid", k), 32'(out_valid), 32'd0);
      chk($sformatf("arst%0d result", k), out_result, 32'd0);
      chk($sformatf("arst%0d illegal", k), 32'(out_illegal), 32'd0);
      chk($sformatf("arst%0d in_ready", k), 32'(in_ready), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      chk($sformatf("arst%0d after", k), 32'(out_valid), 32'd0);
    end

`ifdef ALU_SEQ_MDU_EN
    in_valid = 1'b1; in_fn = ALU_DIV; in_a = 32'd100; in_b = 32'd7;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (5) @(negedge clk);
    rst_n = 1'b0;
    #1 chk("busy reset in_ready", 32'(in_ready), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    vcnt = 0;
    repeat (40) begin
      if (out_valid) vcnt++;
      @(negedge clk);
    end
    chk("busy reset no result", 32'(vcnt), 32'd0);
`endif

    // Randomized ops against the reference model
    for (int i = 0; i < 150; i++) begin
      if ($urandom_range(0, 9) == 0) rf = 5'($urandom_range(0, 31));
      else rf = fns[$urandom_range(0, 18)];
      ra = rnd_op32();
      rb = rnd_op32();
      model(rf, ra, rb, er, eil, elat);
      run_op($sformatf("rnd%0d fn=%h a=%h b=%h", i, rf, ra, rb), rf, ra, rb, er, eil, elat);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
